uart_core_param: RTL and testbench
==================================

// Module: uart_core_param
// PURPOSE
//  Parametrised full-duplex UART for the CPLD host link; next generation of the fixed 8N1 codec.
//  Single-clock design with an internal baud divider, configurable frame format and a
//  per-byte valid/ready TX handshake. Adds framing-error detection, start-glitch rejection and optional parity.
// PARAMETERS
//  CLKS_PER_BIT  16  clock cycles per serial bit; min 4; counter width $clog2(CLKS_PER_BIT)
//  DATA_BITS     8   data bits per frame, 5..9, LSB first
//  STOP_BITS     1   TX stop bits, 1 or 2; RX checks first stop bit only
//  PARITY_ODD    0   0=even, 1=odd; used only when UART_PARITY_EN defined
// PORTS
//  clock          in   1          system clock; all logic on posedge
//  reset          in   1          synchronous, active-high
//  rx             in   1          async serial input, idle high
//  tx             out  1          serial output, idle high
//  tx_data        in   DATA_BITS  byte to send
//  tx_valid       in   1          tx_data valid
//  tx_ready       out  1          TX idle, can accept; transfer when tx_valid&&tx_ready
//  rx_data        out  DATA_BITS  last received byte, held until next
//  rx_valid       out  1          1-cycle pulse, new rx_data
//  rx_frame_err   out  1          with rx_valid: stop bit sampled 0
//  rx_parity_err  out  1          with rx_valid: parity mismatch (constant 0 without macro)
// BEHAVIOUR
//  Reset (sync): tx=1, tx_ready=1, rx_data=0, rx_valid=0, both err=0, FSMs IDLE, counters 0.
//   Reset mid-frame aborts both directions: tx=1 at next edge, partial RX discarded, no rx_valid.
//  TX FSM IDLE->START->DATA->[PARITY]->STOP->IDLE. On handshake in IDLE, latch tx_data,
//   tx_ready=0 next cycle; tx drives start bit (0) from the cycle after handshake.
//   Each bit holds exactly CLKS_PER_BIT cycles; data LSB first; then STOP_BITS stop bits (1).
//   After final stop period: one IDLE cycle with tx=1, tx_ready=1; back-to-back frames
//   have exactly 1 extra idle clock. tx_valid with tx_ready=0 is ignored (no capture).
//  RX: rx passes 2-flop synchroniser (reset value 1); edge detect on synced signal.
//   FSM IDLE->START->DATA->[PARITY]->STOP->(WAIT_HIGH)->IDLE.
//   IDLE: synced falling edge -> START, count CLKS_PER_BIT/2 (integer divide) to bit centre.
//   START centre: synced rx=1 -> glitch, back to IDLE, no output; else sample each following
//   bit every CLKS_PER_BIT cycles at centre, shift in LSB first.
//   STOP centre: next cycle rx_valid=1 (1 cycle), rx_data updated, rx_frame_err=!stop,
//   rx_parity_err=mismatch. err flags are 0 whenever rx_valid=0.
//   Stop sampled 1 -> IDLE immediately (next start edge accepted mid-stop).
//   Stop sampled 0 -> WAIT_HIGH until synced rx=1 (break), then IDLE; no frames during break.
//  RX and TX fully independent; simultaneous activity allowed.
//  Latency rx pin -> rx_valid: 2 sync + CLKS_PER_BIT/2 + (DATA_BITS+P+1)*CLKS_PER_BIT + 1 cycles.
// CONFIGURATION
//  UART_PARITY_EN defined: parity bit after data, even/odd per PARITY_ODD (bit makes total
//   count of ones even/odd); RX checks it and drives rx_parity_err; PARITY states present.
//  Not defined: no parity bit, PARITY states removed, rx_parity_err tied 0, PARITY_ODD ignored.
// TESTING (CLKS_PER_BIT=16, DATA_BITS=8, STOP_BITS=1)
//  1 TX 0xA5 handshake at cycle T -> tx=0 cycles T+1..T+16, then 1,0,1,0,0,1,0,1 each 16
//    cycles, stop=1 16 cycles; tx_ready=0 T+1..T+160, =1 at T+161.
//  2 Loopback tx->rx, tx_valid held with 0x00,0xFF,0x5A -> three rx_valid pulses, rx_data
//    0x00,0xFF,0x5A in order, all err=0, frame spacing 161 cycles.
//  3 rx low for 4 cycles then high -> glitch rejected: no rx_valid, RX back to IDLE, next good
//    frame 0x3C received correctly.
//  4 RX frame 0x81 with stop bit=0, then rx low 40 cycles -> rx_valid=1 with rx_frame_err=1,
//    rx_data=0x81; no rx_valid during the low period; next frame after line high OK.
//  5 UART_PARITY_EN, PARITY_ODD=1: TX 0x07 -> parity bit 0; RX 0x07 with parity 1
//    -> rx_valid with rx_parity_err=1, rx_frame_err=0.
//  6 Assert reset 1 cycle at TX bit 3 and RX bit 4 -> tx=1, tx_ready=1 next edge, no rx_valid;
//    following frame 0x11 transmits and receives cleanly.

Source files
------------

// File: rtl/uart_core_param_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_core_param_if
//  Description : Serial pins plus TX/RX byte handshake of uart_core_param.
//                master : host side (drives rx line, tx_data, tx_valid)
//                slave  : UART core side
//  Ports       : rx, tx                      serial lines, idle high
//                tx_data, tx_valid, tx_ready per-byte TX handshake
//                rx_data, rx_valid           received byte + 1-cycle strobe
//                rx_frame_err, rx_parity_err error flags qualified by rx_valid
//  Revision    : 1.0  initial release
// ============================================================================
interface uart_core_param_if #(
    parameter int DATA_BITS = 8
);
    logic                 rx;
    logic                 tx;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_frame_err;
    logic                 rx_parity_err;

    modport master (
        output rx, tx_data, tx_valid,
        input  tx, tx_ready, rx_data, rx_valid, rx_frame_err, rx_parity_err
    );

    modport slave (
        input  rx, tx_data, tx_valid,
        output tx, tx_ready, rx_data, rx_valid, rx_frame_err, rx_parity_err
    );
endinterface
`default_nettype wire

// File: rtl/uart_core_param.sv
`default_nettype none
// ============================================================================
//  Module      : uart_core_param
//  Description : Parametrised full-duplex UART, single clock, internal baud
//                divider, valid/ready TX handshake, framing-error detection,
//                start-glitch rejection. Optional parity bit enabled by the
//                UART_PARITY_EN macro (even/odd selected by PARITY_ODD).
//  Ports       : clock  in   system clock, posedge
//                reset  in   synchronous, active-high
//                bus    if   uart_core_param_if.slave
//                       (rx, tx, tx_data/tx_valid/tx_ready,
//                        rx_data/rx_valid/rx_frame_err/rx_parity_err)
//  Revision    : 1.0  initial release
// ============================================================================
module uart_core_param #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  wire logic           clock,
    input  wire logic           reset,
    uart_core_param_if.slave    bus
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] c_bit_last  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] c_half_last = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0] c_idx_last  = IDX_W'(DATA_BITS - 1);
    localparam logic             c_stop_last = 1'(STOP_BITS - 1);

`ifdef UART_PARITY_EN
    localparam logic c_par_odd = 1'(PARITY_ODD);

    typedef enum logic [2:0] {
        TX_IDLE = 3'd0, TX_START = 3'd1, TX_DATA = 3'd2, TX_PARITY = 3'd3, TX_STOP = 3'd4
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE = 3'd0, RX_START = 3'd1, RX_DATA = 3'd2, RX_PARITY = 3'd3,
        RX_STOP = 3'd4, RX_WAIT_HIGH = 3'd5
    } rx_state_t;
`else
    typedef enum logic [2:0] {
        TX_IDLE = 3'd0, TX_START = 3'd1, TX_DATA = 3'd2, TX_STOP = 3'd4
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE = 3'd0, RX_START = 3'd1, RX_DATA = 3'd2, RX_STOP = 3'd4, RX_WAIT_HIGH = 3'd5
    } rx_state_t;
`endif

    // ------------------------------------------------------------------ TX
    tx_state_t              tx_state_q, tx_state_d;
    logic [CNT_W-1:0]       tx_cnt_q,   tx_cnt_d;
    logic [IDX_W-1:0]       tx_idx_q,   tx_idx_d;
    logic                   tx_stop_q,  tx_stop_d;
    logic [DATA_BITS-1:0]   tx_shift_q, tx_shift_d;
    logic                   tx_q,       tx_d;
    logic                   tx_ready_q, tx_ready_d;
`ifdef UART_PARITY_EN
    logic                   tx_par_q,   tx_par_d;
`endif
    logic                   w_tx_bit_end;

    assign w_tx_bit_end = (tx_cnt_q == c_bit_last);

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_idx_d   = tx_idx_q;
        tx_stop_d  = tx_stop_q;
        tx_shift_d = tx_shift_q;
        tx_d       = tx_q;
        tx_ready_d = tx_ready_q;
`ifdef UART_PARITY_EN
        tx_par_d   = tx_par_q;
`endif
        // Every non-idle state is one bit period long; tx is registered so
        // the next bit level is loaded on the last count of the current bit.
        if (tx_state_q != TX_IDLE) begin
            tx_cnt_d = w_tx_bit_end ? '0 : tx_cnt_q + 1'b1;
        end

        case (tx_state_q)
            TX_IDLE: begin
                if (bus.tx_valid && tx_ready_q) begin
                    tx_state_d = TX_START;
                    tx_cnt_d   = '0;
                    tx_shift_d = bus.tx_data;
                    tx_d       = 1'b0;
                    tx_ready_d = 1'b0;
`ifdef UART_PARITY_EN
                    tx_par_d   = (^bus.tx_data) ^ c_par_odd;
`endif
                end
            end
            TX_START: begin
                if (w_tx_bit_end) begin
                    tx_state_d = TX_DATA;
                    tx_idx_d   = '0;
                    tx_d       = tx_shift_q[0];
                end
            end
            TX_DATA: begin
                if (w_tx_bit_end) begin
                    if (tx_idx_q == c_idx_last) begin
`ifdef UART_PARITY_EN
                        tx_state_d = TX_PARITY;
                        tx_d       = tx_par_q;
`else
                        tx_state_d = TX_STOP;
                        tx_stop_d  = 1'b0;
                        tx_d       = 1'b1;
`endif
                    end else begin
                        tx_idx_d   = tx_idx_q + 1'b1;
                        tx_shift_d = tx_shift_q >> 1;
                        tx_d       = tx_shift_q[1];
                    end
                end
            end
`ifdef UART_PARITY_EN
            TX_PARITY: begin
                if (w_tx_bit_end) begin
                    tx_state_d = TX_STOP;
                    tx_stop_d  = 1'b0;
                    tx_d       = 1'b1;
                end
            end
`endif
            TX_STOP: begin
                if (w_tx_bit_end) begin
                    if (tx_stop_q == c_stop_last) begin
                        // Ready rises together with IDLE: one idle clock
                        // separates back-to-back frames.
                        tx_state_d = TX_IDLE;
                        tx_ready_d = 1'b1;
                    end else begin
                        tx_stop_d  = tx_stop_q + 1'b1;
                    end
                end
            end
            default: begin
                tx_state_d = TX_IDLE;
                tx_d       = 1'b1;
                tx_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_stop_q  <= 1'b0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
            tx_ready_q <= 1'b1;
`ifdef UART_PARITY_EN
            tx_par_q   <= 1'b0;
`endif
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_idx_q   <= tx_idx_d;
            tx_stop_q  <= tx_stop_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
            tx_ready_q <= tx_ready_d;
`ifdef UART_PARITY_EN
            tx_par_q   <= tx_par_d;
`endif
        end
    end

    assign bus.tx       = tx_q;
    assign bus.tx_ready = tx_ready_q;

    // ------------------------------------------------------------------ RX
    // Two-flop synchroniser plus one history flop for falling-edge detect.
    logic                   rx_s1_q, rx_s2_q, rx_prev_q;
    rx_state_t              rx_state_q, rx_state_d;
    logic [CNT_W-1:0]       rx_cnt_q,   rx_cnt_d;
    logic [IDX_W-1:0]       rx_idx_q,   rx_idx_d;
    logic [DATA_BITS-1:0]   rx_shift_q, rx_shift_d;
    logic [DATA_BITS-1:0]   rx_data_q,  rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   rx_ferr_q,  rx_ferr_d;
`ifdef UART_PARITY_EN
    logic                   rx_pbit_q,  rx_pbit_d;
    logic                   rx_perr_q,  rx_perr_d;
`endif
    logic                   w_rx_fall;
    logic                   w_rx_bit_end;

    assign w_rx_fall    = rx_prev_q & ~rx_s2_q;
    assign w_rx_bit_end = (rx_cnt_q == c_bit_last);

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_idx_d   = rx_idx_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_ferr_d  = 1'b0;
`ifdef UART_PARITY_EN
        rx_pbit_d  = rx_pbit_q;
        rx_perr_d  = 1'b0;
`endif
        case (rx_state_q)
            RX_IDLE: begin
                if (w_rx_fall) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = '0;
                end
            end
            RX_START: begin
                // Half a bit to reach the centre; a line back high there is
                // treated as noise rather than a start bit.
                if (rx_cnt_q == c_half_last) begin
                    rx_cnt_d   = '0;
                    rx_idx_d   = '0;
                    rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d   = rx_cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (w_rx_bit_end) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_idx_q == c_idx_last) begin
`ifdef UART_PARITY_EN
                        rx_state_d = RX_PARITY;
`else
                        rx_state_d = RX_STOP;
`endif
                    end else begin
                        rx_idx_d   = rx_idx_q + 1'b1;
                    end
                end else begin
                    rx_cnt_d   = rx_cnt_q + 1'b1;
                end
            end
`ifdef UART_PARITY_EN
            RX_PARITY: begin
                if (w_rx_bit_end) begin
                    rx_cnt_d   = '0;
                    rx_pbit_d  = rx_s2_q;
                    rx_state_d = RX_STOP;
                end else begin
                    rx_cnt_d   = rx_cnt_q + 1'b1;
                end
            end
`endif
            RX_STOP: begin
                if (w_rx_bit_end) begin
                    rx_cnt_d   = '0;
                    rx_valid_d = 1'b1;
                    rx_data_d  = rx_shift_q;
                    rx_ferr_d  = ~rx_s2_q;
`ifdef UART_PARITY_EN
                    rx_perr_d  = ((^rx_shift_q) ^ rx_pbit_q) != c_par_odd;
`endif
                    // A low stop bit means a break: wait for the line to
                    // return high before looking for another start edge.
                    rx_state_d = rx_s2_q ? RX_IDLE : RX_WAIT_HIGH;
                end else begin
                    rx_cnt_d   = rx_cnt_q + 1'b1;
                end
            end
            RX_WAIT_HIGH: begin
                if (rx_s2_q) begin
                    rx_state_d = RX_IDLE;
                end
            end
            default: begin
                rx_state_d = RX_IDLE;
                rx_cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
`ifdef UART_PARITY_EN
            rx_pbit_q  <= 1'b0;
            rx_perr_q  <= 1'b0;
`endif
        end else begin
            rx_s1_q    <= bus.rx;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_idx_q   <= rx_idx_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_ferr_q  <= rx_ferr_d;
`ifdef UART_PARITY_EN
            rx_pbit_q  <= rx_pbit_d;
            rx_perr_q  <= rx_perr_d;
`endif
        end
    end

    assign bus.rx_data      = rx_data_q;
    assign bus.rx_valid     = rx_valid_q;
    assign bus.rx_frame_err = rx_ferr_q;
`ifdef UART_PARITY_EN
    assign bus.rx_parity_err = rx_perr_q;
`else
    assign bus.rx_parity_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_core_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_core_param
//  Description : Self-checking bench for uart_core_param. Frames are modelled
//                as a list of bit levels (start, data LSB first, optional
//                parity, stop) each lasting CLKS cycles.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_core_param;

    localparam int CLKS  = 16;
    localparam int DBITS = 8;
    localparam int SBITS = 1;
    localparam int PODD  = 1;
`ifdef UART_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif
    localparam int FRAME_BITS = 1 + DBITS + PBITS + SBITS;
    localparam int FRAME_CYC  = FRAME_BITS * CLKS;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic loopback = 1'b0;
    logic rx_drv = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    uart_core_param_if #(.DATA_BITS(DBITS)) bus ();

    uart_core_param #(
        .CLKS_PER_BIT (CLKS),
        .DATA_BITS    (DBITS),
        .STOP_BITS    (SBITS),
        .PARITY_ODD   (PODD)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.rx = loopback ? bus.tx : rx_drv;

    // Receive monitor: records every rx_valid strobe; counts error flags
    // seen while rx_valid is low.
    logic [DBITS-1:0] got_data[$];
    logic             got_ferr[$];
    logic             got_perr[$];
    int               got_cyc[$];
    int               stray_err = 0;

    always @(negedge clock) begin
        if (bus.rx_valid === 1'b1) begin
            got_data.push_back(bus.rx_data);
            got_ferr.push_back(bus.rx_frame_err);
            got_perr.push_back(bus.rx_parity_err);
            got_cyc.push_back(cyc);
        end else if (bus.rx_frame_err !== 1'b0 || bus.rx_parity_err !== 1'b0) begin
            stray_err <= stray_err + 1;
        end
    end

    // ---------------------------------------------------------- model
    function automatic int ones(input logic [DBITS-1:0] d);
        int n = 0;
        for (int i = 0; i < DBITS; i++) n += int'(d[i]);
        return n;
    endfunction

    function automatic logic par_bit(input logic [DBITS-1:0] d);
        return ((ones(d) + PODD) % 2) == 1;
    endfunction

    // Level of bit slot k of a frame carrying d (stop slots are 1).
    function automatic logic frame_bit(input logic [DBITS-1:0] d, input int k);
        if (k == 0) return 1'b0;
        if (k <= DBITS) return d[k-1];
        if (PBITS == 1 && k == DBITS + 1) return par_bit(d);
        return 1'b1;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_tx_ready();
        int n = 0;
        while (bus.tx_ready !== 1'b1 && n < 4 * FRAME_CYC) begin
            tick();
            n++;
        end
        if (bus.tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL tx_ready_timeout: tx_ready=%b, required 1", bus.tx_ready);
        end
    endtask

    task automatic wait_rx(input int count);
        int n = 0;
        while (got_data.size() < count && n < 4 * FRAME_CYC) begin
            tick();
            n++;
        end
    endtask

    // Drive one frame on rx_drv; stop level and parity inversion selectable.
    task automatic send_rx(input logic [DBITS-1:0] d, input logic stop_lvl, input logic pflip);
        for (int k = 0; k < FRAME_BITS - SBITS + 1; k++) begin
            if (k == FRAME_BITS - SBITS) rx_drv = stop_lvl;
            else if (PBITS == 1 && k == DBITS + 1) rx_drv = frame_bit(d, k) ^ pflip;
            else rx_drv = frame_bit(d, k);
            repeat (CLKS) tick();
        end
    endtask

    // Called right after the handshake edge; checks every cycle of the frame.
    task automatic check_tx_frame(input logic [DBITS-1:0] d, input bit poke);
        for (int k = 0; k < FRAME_CYC; k++) begin
            checks++;
            if (bus.tx !== frame_bit(d, k / CLKS) || bus.tx_ready !== 1'b0) begin
                errors++;
                $display("FAIL tx_wave byte %h cycle %0d: tx=%b ready=%b, required tx=%b ready=0",
                         d, k, bus.tx, bus.tx_ready, frame_bit(d, k / CLKS));
            end
            if (poke) begin
                bus.tx_valid = (k >= 30 && k < 40);
                bus.tx_data  = ~d;
            end
            tick();
        end
        checks++;
        if (bus.tx !== 1'b1 || bus.tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL tx_idle_after_frame: tx=%b ready=%b, required 1/1", bus.tx, bus.tx_ready);
        end
    endtask

    // ---------------------------------------------------------- tests
    task automatic test_reset();
        bus.tx_valid = 1'b0;
        bus.tx_data  = '0;
        reset = 1'b1;
        repeat (3) tick();
        checks++;
        if (bus.tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b, required 1", bus.tx); end
        checks++;
        if (bus.tx_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready: got %b, required 1", bus.tx_ready); end
        checks++;
        if (bus.rx_data !== '0) begin errors++; $display("FAIL reset_rx_data: got %h, required 00", bus.rx_data); end
        checks++;
        if (bus.rx_valid !== 1'b0 || bus.rx_frame_err !== 1'b0 || bus.rx_parity_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_rx_flags: valid/ferr/perr=%b%b%b, required 000",
                     bus.rx_valid, bus.rx_frame_err, bus.rx_parity_err);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_tx_frames();
        logic [DBITS-1:0] d;
        for (int i = 0; i < 4; i++) begin
            d = (i == 0) ? DBITS'(8'hA5) : DBITS'($urandom);
            wait_tx_ready();
            bus.tx_data  = d;
            bus.tx_valid = 1'b1;
            tick();
            bus.tx_valid = 1'b0;
            check_tx_frame(d, i < 2);
        end
    endtask

    task automatic test_rx_frames();
        logic [DBITS-1:0] exp[$];
        int base = got_data.size();
        for (int i = 0; i < 5; i++) exp.push_back(DBITS'($urandom));
        foreach (exp[i]) send_rx(exp[i], 1'b1, 1'b0);
        wait_rx(base + exp.size());
        checks++;
        if (got_data.size() != base + exp.size()) begin
            errors++;
            $display("FAIL rx_count: got %0d frames, required %0d", got_data.size() - base, exp.size());
        end else begin
            foreach (exp[i]) begin
                checks++;
                if (got_data[base+i] !== exp[i] || got_ferr[base+i] !== 1'b0 || got_perr[base+i] !== 1'b0) begin
                    errors++;
                    $display("FAIL rx_frame %0d: data=%h ferr=%b perr=%b, required %h 0 0",
                             i, got_data[base+i], got_ferr[base+i], got_perr[base+i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_loopback_back_to_back();
        logic [DBITS-1:0] v[$];
        int base = got_data.size();
        v.push_back(DBITS'(8'h00)); v.push_back(DBITS'(8'hFF)); v.push_back(DBITS'(8'h5A));
        v.push_back(DBITS'($urandom)); v.push_back(DBITS'($urandom));
        loopback = 1'b1;
        tick();
        foreach (v[i]) begin
            wait_tx_ready();
            bus.tx_data  = v[i];
            bus.tx_valid = 1'b1;
            tick();
        end
        bus.tx_valid = 1'b0;
        wait_rx(base + v.size());
        repeat (CLKS) tick();
        checks++;
        if (got_data.size() != base + v.size()) begin
            errors++;
            $display("FAIL loop_count: got %0d frames, required %0d", got_data.size() - base, v.size());
        end else begin
            foreach (v[i]) begin
                checks++;
                if (got_data[base+i] !== v[i] || got_ferr[base+i] !== 1'b0 || got_perr[base+i] !== 1'b0) begin
                    errors++;
                    $display("FAIL loop_frame %0d: data=%h ferr=%b perr=%b, required %h 0 0",
                             i, got_data[base+i], got_ferr[base+i], got_perr[base+i], v[i]);
                end
                if (i > 0) begin
                    checks++;
                    if (got_cyc[base+i] - got_cyc[base+i-1] != FRAME_CYC + 1) begin
                        errors++;
                        $display("FAIL loop_spacing %0d: got %0d cycles, required %0d",
                                 i, got_cyc[base+i] - got_cyc[base+i-1], FRAME_CYC + 1);
                    end
                end
            end
        end
        loopback = 1'b0;
        tick();
    endtask

    task automatic test_glitch();
        int base = got_data.size();
        rx_drv = 1'b0;
        repeat (4) tick();
        rx_drv = 1'b1;
        repeat (3 * CLKS) tick();
        checks++;
        if (got_data.size() != base) begin
            errors++;
            $display("FAIL glitch_no_output: got %0d frames, required 0", got_data.size() - base);
        end
        send_rx(DBITS'(8'h3C), 1'b1, 1'b0);
        wait_rx(base + 1);
        checks++;
        if (got_data.size() != base + 1 || got_data[base] !== DBITS'(8'h3C) || got_ferr[base] !== 1'b0) begin
            errors++;
            $display("FAIL glitch_next_frame: frames=%0d, required 1 frame of 3c with ferr 0",
                     got_data.size() - base);
        end
    endtask

    task automatic test_frame_error();
        logic [DBITS-1:0] d = DBITS'($urandom);
        int base = got_data.size();
        send_rx(DBITS'(8'h81), 1'b0, 1'b0);
        repeat (40) tick();
        checks++;
        if (got_data.size() != base + 1) begin
            errors++;
            $display("FAIL ferr_count: got %0d frames, required 1", got_data.size() - base);
        end else begin
            checks++;
            if (got_data[base] !== DBITS'(8'h81) || got_ferr[base] !== 1'b1 || got_perr[base] !== 1'b0) begin
                errors++;
                $display("FAIL ferr_frame: data=%h ferr=%b perr=%b, required 81 1 0",
                         got_data[base], got_ferr[base], got_perr[base]);
            end
        end
        rx_drv = 1'b1;
        repeat (CLKS) tick();
        send_rx(d, 1'b1, 1'b0);
        wait_rx(base + 2);
        checks++;
        if (got_data.size() != base + 2 || got_data[base+1] !== d || got_ferr[base+1] !== 1'b0) begin
            errors++;
            $display("FAIL ferr_recovery: frames=%0d, required 2 with second %h ferr 0",
                     got_data.size() - base, d);
        end
    endtask

`ifdef UART_PARITY_EN
    task automatic test_parity();
        int base = got_data.size();
        wait_tx_ready();
        bus.tx_data  = DBITS'(8'h07);
        bus.tx_valid = 1'b1;
        tick();
        bus.tx_valid = 1'b0;
        check_tx_frame(DBITS'(8'h07), 1'b0);
        send_rx(DBITS'(8'h07), 1'b1, 1'b1);
        send_rx(DBITS'(8'h07), 1'b1, 1'b0);
        wait_rx(base + 2);
        checks++;
        if (got_data.size() != base + 2) begin
            errors++;
            $display("FAIL parity_count: got %0d frames, required 2", got_data.size() - base);
        end else begin
            checks++;
            if (got_perr[base] !== 1'b1 || got_ferr[base] !== 1'b0 || got_data[base] !== DBITS'(8'h07)) begin
                errors++;
                $display("FAIL parity_bad: data=%h perr=%b ferr=%b, required 07 1 0",
                         got_data[base], got_perr[base], got_ferr[base]);
            end
            checks++;
            if (got_perr[base+1] !== 1'b0 || got_ferr[base+1] !== 1'b0) begin
                errors++;
                $display("FAIL parity_good: perr=%b ferr=%b, required 0 0", got_perr[base+1], got_ferr[base+1]);
            end
        end
    endtask
`endif

    task automatic test_reset_midframe();
        logic [DBITS-1:0] rd = DBITS'($urandom);
        logic [DBITS-1:0] td = DBITS'($urandom);
        int base = got_data.size();
        // RX frame starts first; TX handshake 16 cycles later, so the reset
        // lands in TX data bit 3 and RX data bit 4.
        for (int c = 0; c < 86; c++) begin
            rx_drv = frame_bit(rd, c / CLKS);
            if (c == 16) begin
                bus.tx_data  = td;
                bus.tx_valid = 1'b1;
            end else begin
                bus.tx_valid = 1'b0;
            end
            tick();
        end
        rx_drv = 1'b1;
        reset  = 1'b1;
        tick();
        checks++;
        if (bus.tx !== 1'b1 || bus.tx_ready !== 1'b1 || bus.rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL midframe_reset: tx=%b ready=%b rx_valid=%b, required 1 1 0",
                     bus.tx, bus.tx_ready, bus.rx_valid);
        end
        reset = 1'b0;
        repeat (2 * FRAME_CYC) tick();
        checks++;
        if (got_data.size() != base) begin
            errors++;
            $display("FAIL midframe_rx_discard: got %0d frames, required 0", got_data.size() - base);
        end
        loopback = 1'b1;
        tick();
        bus.tx_data  = DBITS'(8'h11);
        bus.tx_valid = 1'b1;
        tick();
        bus.tx_valid = 1'b0;
        check_tx_frame(DBITS'(8'h11), 1'b0);
        wait_rx(base + 1);
        checks++;
        if (got_data.size() != base + 1 || got_data[base] !== DBITS'(8'h11) || got_ferr[base] !== 1'b0) begin
            errors++;
            $display("FAIL midframe_next_frame: frames=%0d, required 1 frame of 11 with ferr 0",
                     got_data.size() - base);
        end
        loopback = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_tx_frames();
        test_rx_frames();
        test_loopback_back_to_back();
        test_glitch();
        test_frame_error();
`ifdef UART_PARITY_EN
        test_parity();
`endif
        test_reset_midframe();
        checks++;
        if (stray_err != 0) begin
            errors++;
            $display("FAIL err_flags_without_valid: seen %0d times, required 0", stray_err);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
